// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial add/subtract controller:
// state encoding, default width and the uio pin map.
package serial_add_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int WIDTH_DEF = 8;

    // Control strobes on uio_in
    localparam int LOAD_A_BIT = 0;
    localparam int LOAD_B_BIT = 1;
    localparam int START_BIT  = 2;
    localparam int SUB_BIT    = 3;

    // Status flags on uio_out
    localparam int BUSY_BIT = 4;
    localparam int DONE_BIT = 5;
    localparam int COUT_BIT = 6;

    // Only the three status pins are ever driven
    localparam logic [7:0] UIO_OE_MASK = 8'h70;

endpackage

// File: rtl/serial_fa_slice.sv
// One-bit full adder built from two half-adder cells. The controller
// reuses this single slice for every bit position, one bit per clock.
module serial_fa_slice (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic ha0Sum;
    logic ha0Carry;
    logic ha1Carry;

    // First half-adder cell combines the two operand bits
    assign ha0Sum   = a ^ b;
    assign ha0Carry = a & b;

    // Second half-adder cell folds in the incoming carry
    assign s        = ha0Sum ^ cin;
    assign ha1Carry = ha0Sum & cin;

    // A carry out of either cell propagates
    assign cout     = ha0Carry | ha1Carry;

endmodule

// File: rtl/tt_um_serial_add_ctrl.sv
// Bit-serial add/subtract controller behind the standard tile pins.
// Operands are loaded from ui_in, then shifted LSB first through one
// shared full-adder slice; the result builds up in a shift register
// that drives uo_out directly.
module tt_um_serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_e           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] sum_q;
    logic             carry_q;
    logic [CNT_W-1:0] cnt_q;
    logic             sub_q;
    logic             busy_q;
    logic             done_q;
    logic             cout_q;

    logic [WIDTH-1:0] a_d;
    logic [WIDTH-1:0] b_d;
    logic [WIDTH-1:0] sum_d;

    logic loadA;
    logic loadB;
    logic loadAny;
    logic startReq;
    logic subReq;
    logic bEff;
    logic sBit;
    logic cNext;
    logic lastBit;

    // ena and the upper uio_in pins carry no function here
    logic unused_ok;
    assign unused_ok = &{1'b0, ena, uio_in[7:4]};

    // Decode the control strobes from the bidirectional input pins
    assign loadA    = uio_in[LOAD_A_BIT];
    assign loadB    = uio_in[LOAD_B_BIT];
    assign startReq = uio_in[START_BIT];
    assign subReq   = uio_in[SUB_BIT];
    assign loadAny  = loadA | loadB;

    // Subtraction is A + ~B + 1: invert B here, the +1 is the seeded carry
    assign bEff    = b_q[0] ^ sub_q;
    assign lastBit = (cnt_q == LAST_CNT);

    serial_fa_slice uFaSlice (
        .a    (a_q[0]),
        .b    (bEff),
        .cin  (carry_q),
        .s    (sBit),
        .cout (cNext)
    );

    // Next values of the operand and result shift registers for one RUN step
    always_comb begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        sum_d = {sBit, sum_q[WIDTH-1:1]};
    end

    // Control FSM with registered status flags; loads beat start in
    // IDLE/DONE, and RUN ignores every strobe until the last bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sub_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cout_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (loadAny) begin
                        if (loadA) a_q <= ui_in[WIDTH-1:0];
                        if (loadB) b_q <= ui_in[WIDTH-1:0];
                        state_q <= IDLE;
                        done_q  <= 1'b0;
                    end else if (startReq) begin
                        state_q <= RUN;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                        cnt_q   <= '0;
                        sum_q   <= '0;
                        sub_q   <= subReq;
                        carry_q <= subReq;
                        cout_q  <= 1'b0;
                    end
                end
                RUN: begin
                    a_q     <= a_d;
                    b_q     <= b_d;
                    sum_q   <= sum_d;
                    carry_q <= cNext;
                    cnt_q   <= cnt_q + CNT_W'(1);
                    if (lastBit) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        cout_q  <= cNext;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    // Result register drives the output pins directly
    assign uo_out = sum_q;

    // Status pins: only busy, done and carry_out are ever non-zero
    always_comb begin
        uio_out           = '0;
        uio_out[BUSY_BIT] = busy_q;
        uio_out[DONE_BIT] = done_q;
        uio_out[COUT_BIT] = cout_q;
    end

    assign uio_oe = UIO_OE_MASK;

endmodule

// File: tb/tb_tt_um_serial_add_ctrl.sv
// Self-checking bench for the bit-serial add/subtract controller.
// A behavioural model computes whole results with plain arithmetic and
// predicts the output pins every cycle; directed scenarios pin the model
// with literal values, then a randomized phase exercises the rest.
module tb_tt_um_serial_add_ctrl;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    logic       loadA;
    logic       loadB;
    logic       startReq;
    logic       subReq;
    logic [3:0] rsvd;

    int passCount = 0;
    int checkCount = 0;

    assign uio_in = {rsvd, subReq, startReq, loadB, loadA};

    tt_um_serial_add_ctrl dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    // Free-running 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check, reports any miss
    task automatic checkOutput(input string name, input int actual, input int expected);
        checkCount++;
        if (actual == expected) passCount++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    endtask

    // ---------------- behavioural model ----------------
    typedef enum {M_IDLE, M_RUN, M_DONE} mstate_e;
    mstate_e mState = M_IDLE;
    int mA = 0, mB = 0, mRes = 0, mRunCout = 0, mSum = 0, mCout = 0, mK = 0;
    int kNext;

    // Model: a run takes eight cycles; after k cycles the low k result
    // bits sit at the top of the result register
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mState <= M_IDLE; mA <= 0; mB <= 0; mRes <= 0;
            mRunCout <= 0; mSum <= 0; mCout <= 0; mK <= 0;
        end else if (mState == M_RUN) begin
            kNext = mK + 1;
            mK   <= kNext;
            mSum <= (mRes << (8 - kNext)) & 255;
            if (kNext == 8) begin
                mState <= M_DONE;
                mCout  <= mRunCout;
                mA     <= 0;
                mB     <= 0;
            end
        end else begin
            if (loadA || loadB) begin
                if (loadA) mA <= int'(ui_in);
                if (loadB) mB <= int'(ui_in);
                mState <= M_IDLE;
            end else if (startReq) begin
                if (subReq) begin
                    mRes     <= (mA - mB) & 255;
                    mRunCout <= (mA >= mB) ? 1 : 0;
                end else begin
                    mRes     <= (mA + mB) & 255;
                    mRunCout <= ((mA + mB) > 255) ? 1 : 0;
                end
                mState <= M_RUN;
                mK     <= 0;
                mSum   <= 0;
                mCout  <= 0;
            end
        end
    end

    // Every falling edge, compare all output pins against the model
    always @(negedge clk) begin
        checkOutput("uo_out", uo_out, mSum);
        checkOutput("busy", uio_out[4], (mState == M_RUN) ? 1 : 0);
        checkOutput("done", uio_out[5], (mState == M_DONE) ? 1 : 0);
        checkOutput("carry_out", uio_out[6], mCout);
        checkOutput("uio_out_rsvd", {uio_out[7], uio_out[3:0]}, 0);
        checkOutput("uio_oe", uio_oe, 8'h70);
    end

    // Drive one cycle of strobes, changing inputs on the falling edge
    task automatic applyStimulus(input logic la, input logic lb, input logic st,
                                 input logic sb, input logic [7:0] d);
        @(negedge clk);
        loadA = la; loadB = lb; startReq = st; subReq = sb; ui_in = d;
    endtask

    // Wait for done with a cycle budget; mode 1 injects strobes at cnt=3,
    // mode 2 asserts reset asynchronously at cnt=5
    task automatic waitDone(input int mode, output int busyCnt);
        bit finished;
        busyCnt  = 0;
        finished = 0;
        for (int i = 0; i < 20 && !finished; i++) begin
            @(negedge clk);
            loadA = 0; loadB = 0; startReq = 0; subReq = 0; ui_in = 8'h00;
            if (uio_out[4]) busyCnt++;
            if (mode == 1 && uio_out[4] && busyCnt == 4) begin
                loadA = 1; startReq = 1; subReq = 1; ui_in = 8'hAA;
            end
            if (mode == 2 && busyCnt == 6) begin
                #2 rst_n = 1'b0;
                #1;
                checkOutput("reset_uo_out", uo_out, 0);
                checkOutput("reset_uio_out", uio_out, 0);
                @(negedge clk);
                @(negedge clk);
                rst_n = 1'b1;
                finished = 1;
            end else if (uio_out[5]) begin
                finished = 1;
            end
        end
        if (!finished) checkOutput("done_timeout", 0, 1);
    endtask

    // Load both operands, launch, and wait for the result
    task automatic runOp(input logic [7:0] a, input logic [7:0] b,
                         input logic sb, input int mode, output int busyCnt);
        applyStimulus(1, 0, 0, 0, a);
        applyStimulus(0, 1, 0, 0, b);
        checkOutput("done_after_load", uio_out[5], 0);
        applyStimulus(0, 0, 1, sb, 8'h00);
        waitDone(mode, busyCnt);
    endtask

    int busyCnt;

    initial begin
        ena = 1'b1; ui_in = 8'h00; rsvd = 4'h0;
        loadA = 0; loadB = 0; startReq = 0; subReq = 0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("rst_uo_out", uo_out, 0);
        checkOutput("rst_uio_out", uio_out, 0);
        checkOutput("rst_uio_oe", uio_oe, 8'h70);
        rst_n = 1'b1;

        // Add without carry
        runOp(8'h5A, 8'h3C, 0, 0, busyCnt);
        checkOutput("add_busy_cycles", busyCnt, 8);
        checkOutput("add_result", uo_out, 8'h96);
        checkOutput("add_cout", uio_out[6], 0);
        checkOutput("add_done", uio_out[5], 1);

        // Add with overflow
        runOp(8'hFF, 8'h01, 0, 0, busyCnt);
        checkOutput("ovf_busy_cycles", busyCnt, 8);
        checkOutput("ovf_result", uo_out, 8'h00);
        checkOutput("ovf_cout", uio_out[6], 1);

        // Subtract, no borrow then borrow
        runOp(8'h10, 8'h01, 1, 0, busyCnt);
        checkOutput("sub_result", uo_out, 8'h0F);
        checkOutput("sub_cout", uio_out[6], 1);
        runOp(8'h01, 8'h02, 1, 0, busyCnt);
        checkOutput("borrow_result", uo_out, 8'hFF);
        checkOutput("borrow_cout", uio_out[6], 0);

        // Strobes during RUN are ignored
        runOp(8'h22, 8'h11, 0, 1, busyCnt);
        checkOutput("intf_busy_cycles", busyCnt, 8);
        checkOutput("intf_result", uo_out, 8'h33);

        // Reset in the middle of a run, then a fresh operation
        runOp(8'h5A, 8'h3C, 0, 2, busyCnt);
        runOp(8'h01, 8'h01, 0, 0, busyCnt);
        checkOutput("post_reset_result", uo_out, 8'h02);

        // Load and start together: load wins
        applyStimulus(1, 1, 1, 0, 8'h07);
        applyStimulus(0, 0, 0, 0, 8'h00);
        checkOutput("loadstart_busy", uio_out[4], 0);
        applyStimulus(0, 0, 1, 0, 8'h00);
        waitDone(0, busyCnt);
        checkOutput("loadstart_result", uo_out, 8'h0E);

        // Re-run without reload works on consumed (zero) operands
        applyStimulus(0, 0, 1, 0, 8'h00);
        waitDone(0, busyCnt);
        checkOutput("rerun_result", uo_out, 8'h00);
        checkOutput("rerun_cout", uio_out[6], 0);

        // Randomized strobes, data and reserved pins, model-checked each cycle
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            loadA    = ($urandom_range(0, 9) == 0);
            loadB    = ($urandom_range(0, 9) == 0);
            startReq = ($urandom_range(0, 2) == 0);
            subReq   = $urandom_range(0, 1);
            ui_in    = 8'($urandom);
            rsvd     = 4'($urandom);
        end
        @(negedge clk);
        loadA = 0; loadB = 0; startReq = 0; subReq = 0; rsvd = 4'h0;
        repeat (12) @(negedge clk);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
